// File: rtl/dsw_scan_ctl.sv
// DIP-switch chain scanner: loads the PISO chain, shifts it out MSB first,
// debounces consecutive scans and tracks configuration readiness.
module dsw_scan_ctl #(
  parameter int unsigned NBITS        = 8,
  parameter int unsigned SCAN_PERIOD  = 250000,
  parameter int unsigned HALF_BIT     = 1,
  parameter int unsigned STABLE_SCANS = 2,
  parameter int unsigned READY_SCANS  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             c_done,
  input  logic             scan_req,
  input  logic             dsw_dat,
  output logic             dsw_sht,
  output logic             dsw_clk,
  output logic [NBITS-1:0] dsw_on,
  output logic             dsw_tp,
  output logic             dsw_chg,
  output logic             scan_busy,
  output logic             cfg_ready
);

  localparam int unsigned PW = $clog2(SCAN_PERIOD);
  localparam int unsigned HW = $clog2(2 * HALF_BIT);
  localparam int unsigned BW = $clog2(NBITS + 1);
  localparam int unsigned SW = $clog2(STABLE_SCANS + 1);
  localparam int unsigned RW = $clog2(READY_SCANS + 1);

  localparam logic [PW-1:0] PerLast  = PW'(SCAN_PERIOD - 1);
  localparam logic [HW-1:0] LoadLast = HW'(2 * HALF_BIT - 1);
  localparam logic [HW-1:0] HalfLast = HW'(HALF_BIT - 1);
  localparam logic [BW-1:0] BitsLast = BW'(NBITS - 1);
  localparam logic [SW-1:0] StabMax  = SW'(STABLE_SCANS);
  localparam logic [RW-1:0] RdyMax   = RW'(READY_SCANS);

  typedef enum logic [2:0] {StIdle, StLoad, StShiftLo, StShiftHi, StDone} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    per_q;
  logic [HW-1:0]    ph_q;
  logic [BW-1:0]    bit_q;
  logic [NBITS-1:0] cap_q;
  logic [NBITS-1:0] cand_q;
  logic [SW-1:0]    stab_q, stab_d;
  logic [RW-1:0]    rdy_q;
  logic [NBITS-1:0] on_q;
  logic             sht_q, sclk_q, busy_q, tp_q, chg_q;
  logic             req_start, sample, publish, din_n;

  // Switches pull the line low when on, so the captured bit is the inverse.
  assign din_n = ~dsw_dat;

  // Next-state decode; a request restarts the period counter, periodic start otherwise.
  always_comb begin
    state_d   = state_q;
    req_start = 1'b0;
    sample    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (scan_req) begin
          state_d   = StLoad;
          req_start = 1'b1;
        end else if (per_q == PerLast) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (ph_q == LoadLast) state_d = StShiftLo;
      end
      StShiftLo: begin
        if (ph_q == HalfLast) begin
          sample  = 1'b1;
          state_d = (bit_q == BitsLast) ? StDone : StShiftHi;
        end
      end
      StShiftHi: begin
        if (ph_q == HalfLast) state_d = StShiftLo;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Debounce: saturating count of identical consecutive scans.
  always_comb begin
    stab_d = SW'(1);
    if (cap_q == cand_q) stab_d = (stab_q >= StabMax) ? StabMax : stab_q + 1'b1;
  end

  assign publish = (stab_d == StabMax) && (cap_q != on_q);

  // State, timing counters and shift capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      per_q   <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_start || per_q == PerLast) per_q <= '0;
      else                               per_q <= per_q + 1'b1;
      if (state_d != state_q || state_q == StIdle) ph_q <= '0;
      else                                         ph_q <= ph_q + 1'b1;
      if (state_q == StIdle) bit_q <= '0;
      else if (sample)       bit_q <= bit_q + 1'b1;
      // Shifting left lands the first sample in the MSB after NBITS samples.
      if (sample) cap_q <= (cap_q << 1) | NBITS'(din_n);
    end
  end

  // Pin outputs registered from the next state so they track the state exactly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sht_q  <= 1'b1;
      sclk_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sht_q  <= (state_d != StLoad);
      sclk_q <= (state_d == StShiftHi);
      busy_q <= (state_d != StIdle);
    end
  end

  // Scan completion: debounce update, strobes and readiness count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cand_q <= '0;
      stab_q <= '0;
      on_q   <= '0;
      tp_q   <= 1'b0;
      chg_q  <= 1'b0;
      rdy_q  <= '0;
    end else begin
      tp_q  <= (state_q == StDone);
      chg_q <= (state_q == StDone) && publish;
      if (state_q == StDone) begin
        cand_q <= cap_q;
        stab_q <= stab_d;
        if (publish) on_q <= cap_q;
      end
      if (!c_done)                                    rdy_q <= '0;
      else if (state_q == StDone && rdy_q != RdyMax) rdy_q <= rdy_q + 1'b1;
    end
  end

  assign dsw_sht   = sht_q;
  assign dsw_clk   = sclk_q;
  assign scan_busy = busy_q;
  assign dsw_on    = on_q;
  assign dsw_tp    = tp_q;
  assign dsw_chg   = chg_q;
  assign cfg_ready = c_done && (rdy_q == RdyMax);

endmodule

// File: tb/tb_dsw_scan_ctl.sv
// Directed bench for dsw_scan_ctl with behavioural PISO switch chains.
module tb_dsw_scan_ctl;

  logic       clk = 1'b0;
  logic       rstn, rstn2, c_done, scan_req;
  logic       dsw_dat, dsw_sht, dsw_clk, dsw_tp, dsw_chg, scan_busy, cfg_ready;
  logic [7:0] dsw_on;
  logic       dsw_dat2, dsw_sht2, dsw_clk2, dsw_tp2, dsw_chg2, scan_busy2, cfg_ready2;
  logic [7:0] dsw_on2;
  logic [7:0] sw1, sw2, sr1, sr2;

  int cyc, n_tests, n_fail;
  int at, pulses, sht_low, tp_at, tp_cnt, chg_cnt, busy_cnt, r, hi_cnt, lo_cnt;
  logic chg, prev_clk;
  logic [60:1] h_clk, h_sht, h_tp, h_busy;

  always #5 clk = ~clk;

  dsw_scan_ctl #(
    .NBITS(8), .SCAN_PERIOD(64), .HALF_BIT(1), .STABLE_SCANS(2), .READY_SCANS(3)
  ) dut (
    .clk(clk), .rstn(rstn), .c_done(c_done), .scan_req(scan_req), .dsw_dat(dsw_dat),
    .dsw_sht(dsw_sht), .dsw_clk(dsw_clk), .dsw_on(dsw_on), .dsw_tp(dsw_tp),
    .dsw_chg(dsw_chg), .scan_busy(scan_busy), .cfg_ready(cfg_ready)
  );

  dsw_scan_ctl #(
    .NBITS(8), .SCAN_PERIOD(64), .HALF_BIT(3), .STABLE_SCANS(2), .READY_SCANS(3)
  ) dut2 (
    .clk(clk), .rstn(rstn2), .c_done(c_done), .scan_req(1'b0), .dsw_dat(dsw_dat2),
    .dsw_sht(dsw_sht2), .dsw_clk(dsw_clk2), .dsw_on(dsw_on2), .dsw_tp(dsw_tp2),
    .dsw_chg(dsw_chg2), .scan_busy(scan_busy2), .cfg_ready(cfg_ready2)
  );

  // PISO chains: load while sht low, shift on rising chain clock; switch on drives 0.
  always @(negedge dsw_sht or posedge dsw_clk) begin
    if (!dsw_sht) sr1 <= ~sw1;
    else          sr1 <= {sr1[6:0], 1'b1};
  end
  assign dsw_dat = sr1[7];

  always @(negedge dsw_sht2 or posedge dsw_clk2) begin
    if (!dsw_sht2) sr2 <= ~sw2;
    else           sr2 <= {sr2[6:0], 1'b1};
  end
  assign dsw_dat2 = sr2[7];

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tp(input int budget, output int t, output logic c);
    t = -1;
    c = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dsw_tp) begin
        t = cyc;
        c = dsw_chg;
        break;
      end
    end
  endtask

  task automatic wait_sht_low(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!dsw_sht) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rstn = 1'b0; rstn2 = 1'b0; c_done = 1'b0; scan_req = 1'b0;
    sw1 = 8'hA5; sw2 = 8'h3C;
    tick(3);
    check("rst_sht", dsw_sht, 1);
    check("rst_clk", dsw_clk, 0);
    check("rst_on", dsw_on, 0);
    check("rst_tp", dsw_tp, 0);
    check("rst_chg", dsw_chg, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_ready", cfg_ready, 0);

    // Basic scan
    rstn = 1'b1; cyc = 0;
    tick(63);
    check("sht_before_64", dsw_sht, 1);
    tick();
    check("sht_fall_64", dsw_sht, 0);
    pulses = 0; tp_at = 0; tp_cnt = 0; chg_cnt = 0;
    prev_clk = dsw_clk;
    sht_low = dsw_sht ? 0 : 1;
    busy_cnt = scan_busy ? 1 : 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (dsw_clk && !prev_clk) pulses++;
      prev_clk = dsw_clk;
      if (!dsw_sht) sht_low++;
      if (scan_busy) busy_cnt++;
      if (dsw_chg) chg_cnt++;
      if (dsw_tp) begin
        tp_cnt++;
        if (tp_at == 0) tp_at = cyc - 64;
      end
    end
    check("load_len", sht_low, 2);
    check("clk_pulses", pulses, 7);
    check("tp_delay", tp_at, 18);
    check("tp_width", tp_cnt, 1);
    check("busy_len", busy_cnt, 18);
    check("scan1_chg", chg_cnt, 0);
    check("scan1_on", dsw_on, 8'h00);
    wait_tp(100, at, chg);
    check("scan2_tp", at, 146);
    check("scan2_chg", chg, 1);
    check("scan2_on", dsw_on, 8'hA5);
    tick();
    check("scan2_chg_width", dsw_chg, 0);

    // Bounce
    sw1 = 8'h01;
    wait_tp(100, at, chg);
    check("b1_tp", at, 210);
    check("b1_chg", chg, 0);
    check("b1_on", dsw_on, 8'hA5);
    sw1 = 8'h02;
    wait_tp(100, at, chg);
    check("b2_tp", at, 274);
    check("b2_chg", chg, 0);
    check("b2_on", dsw_on, 8'hA5);
    wait_tp(100, at, chg);
    check("b3_tp", at, 338);
    check("b3_chg", chg, 1);
    check("b3_on", dsw_on, 8'h02);
    wait_tp(100, at, chg);
    check("b4_tp", at, 402);
    check("b4_chg", chg, 0);
    check("b4_on", dsw_on, 8'h02);

    // Request handshake
    tick(8);
    scan_req = 1'b1;
    tick();
    scan_req = 1'b0;
    check("req_sht", dsw_sht, 0);
    check("req_cyc", cyc, 411);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (scan_busy) busy_cnt++;
      else break;
      scan_req = (i == 3);
      tick();
    end
    scan_req = 1'b0;
    check("req_busy_len", busy_cnt, 18);
    check("req_tp", dsw_tp, 1);
    wait_sht_low(100, at);
    check("req_next_periodic", at, 475);
    wait_tp(100, at, chg);
    check("req_next_tp", at, 493);

    // Readiness
    check("ready_low_cdone0", cfg_ready, 0);
    c_done = 1'b1;
    wait_tp(100, at, chg);
    check("rdy1_tp", at, 557);
    check("rdy1", cfg_ready, 0);
    wait_tp(100, at, chg);
    check("rdy2", cfg_ready, 0);
    wait_tp(100, at, chg);
    check("rdy3_tp", at, 685);
    check("rdy3", cfg_ready, 1);
    c_done = 1'b0;
    #1;
    check("rdy_drop_comb", cfg_ready, 0);
    tick();
    c_done = 1'b1;
    #1;
    check("rdy_reraise", cfg_ready, 0);
    wait_tp(100, at, chg);
    check("rr1", cfg_ready, 0);
    wait_tp(100, at, chg);
    check("rr2", cfg_ready, 0);
    wait_tp(100, at, chg);
    check("rr3_tp", at, 877);
    check("rr3", cfg_ready, 1);

    // Reset mid-scan, during SHIFT_HI
    at = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (dsw_clk) begin
        at = cyc;
        break;
      end
    end
    check("midscan_shift_hi", at, 926);
    rstn = 1'b0;
    #1;
    check("mrst_sht", dsw_sht, 1);
    check("mrst_clk", dsw_clk, 0);
    check("mrst_on", dsw_on, 0);
    check("mrst_tp", dsw_tp, 0);
    check("mrst_chg", dsw_chg, 0);
    check("mrst_busy", scan_busy, 0);
    check("mrst_ready", cfg_ready, 0);
    tick(2);
    rstn = 1'b1; cyc = 0;
    wait_sht_low(100, at);
    check("mrst_first_scan", at, 64);
    wait_tp(100, at, chg);
    check("mrst_s1_tp", at, 82);
    check("mrst_s1_on", dsw_on, 8'h00);
    wait_tp(100, at, chg);
    check("mrst_s2_tp", at, 146);
    check("mrst_s2_chg", chg, 1);
    check("mrst_s2_on", dsw_on, 8'h02);

    // Slow shift clock on the second instance
    rstn2 = 1'b1; r = cyc;
    at = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!dsw_sht2) begin
        at = cyc - r;
        break;
      end
    end
    check("slow_first_scan", at, 64);
    for (int i = 1; i <= 60; i++) begin
      if (i > 1) tick();
      h_clk[i] = dsw_clk2;
      h_sht[i] = dsw_sht2;
      h_tp[i] = dsw_tp2;
      h_busy[i] = scan_busy2;
    end
    sht_low = 0; pulses = 0; hi_cnt = 0; tp_at = 0;
    for (int i = 1; i <= 60; i++) begin
      if (!h_sht[i]) sht_low++;
      if (h_clk[i]) hi_cnt++;
      if (i > 1 && h_clk[i] && !h_clk[i-1]) pulses++;
      if (h_tp[i] && tp_at == 0) tp_at = i - 1;
    end
    lo_cnt = 0;
    for (int i = 13; i <= 15; i++) if (!h_clk[i]) lo_cnt++;
    check("slow_load_len", sht_low, 6);
    check("slow_pulses", pulses, 7);
    check("slow_hi_total", hi_cnt, 21);
    check("slow_hi_start", h_clk[10], 1);
    check("slow_hi_end", h_clk[12], 1);
    check("slow_lo_run", lo_cnt, 3);
    check("slow_lo_before", h_clk[9], 0);
    check("slow_hi_next", h_clk[16], 1);
    check("slow_scan_len", tp_at, 52);
    check("slow_busy_done", h_busy[52], 1);
    check("slow_busy_idle", h_busy[53], 0);
    check("slow_s1_on", dsw_on2, 8'h00);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (dsw_tp2) begin
        at = cyc - r;
        break;
      end
    end
    check("slow_s2_tp", at, 180);
    check("slow_s2_on", dsw_on2, 8'h3C);
    check("slow_s2_chg", dsw_chg2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
